// File: rtl/controle_estado.sv
// Irrigation controller: synchronizes and debounces the operator buttons, then
// sequences the fill valve and the irrigation pump, raising an alarm when the
// tank takes too long to fill.
module controle_estado #(
   parameter int unsigned DEBOUNCE_CICLOS = 4,
   parameter int unsigned TEMPO_IRRIGA    = 10,
   parameter int unsigned TEMPO_MAX_ENCHE = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       parar,
   input  logic       cheio,
   output logic [1:0] estado,
   output logic       valvula,
   output logic       bomba,
   output logic       alarme
);

   typedef enum logic [1:0] {
      StOcioso    = 2'b00,
      StEnchendo  = 2'b01,
      StIrrigando = 2'b10,
      StErro      = 2'b11
   } estado_e;

   // Terminal values compared against the counters before they increment.
   localparam logic [7:0]  DebFim    = 8'(DEBOUNCE_CICLOS - 1);
   localparam logic [15:0] IrrigaFim = 16'(TEMPO_IRRIGA - 1);
   localparam logic [15:0] EncheFim  = 16'(TEMPO_MAX_ENCHE - 1);

   // Bit 0 = iniciar, bit 1 = parar, bit 2 = cheio.
   logic [2:0] sync1_q, sync2_q;

   // Debouncer state, index 0 = iniciar, index 1 = parar.
   logic [1:0] aceito_q, aceito_d;
   logic [1:0] pulso_q, pulso_d;
   logic [7:0] deb_cnt_q [2];
   logic [7:0] deb_cnt_d [2];

   estado_e     state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        valvula_q, bomba_q, alarme_q;

   // Two-flop synchronizers for all asynchronous inputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {cheio, parar, iniciar};
         sync2_q <= sync1_q;
      end
   end

   // Debounce next state: accept a new level after DEBOUNCE_CICLOS differing
   // samples in a row, pulsing only when the accepted level rises.
   always_comb begin
      aceito_d  = aceito_q;
      pulso_d   = '0;
      deb_cnt_d = deb_cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == aceito_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (deb_cnt_q[i] == DebFim) begin
            aceito_d[i]  = sync2_q[i];
            pulso_d[i]   = sync2_q[i];
            deb_cnt_d[i] = '0;
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
         end
      end
   end

   // Debounce registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         aceito_q     <= '0;
         pulso_q      <= '0;
         deb_cnt_q[0] <= '0;
         deb_cnt_q[1] <= '0;
      end else begin
         aceito_q     <= aceito_d;
         pulso_q      <= pulso_d;
         deb_cnt_q[0] <= deb_cnt_d[0];
         deb_cnt_q[1] <= deb_cnt_d[1];
      end
   end

   // FSM next state with priority parar > cheio > timeout > iniciar.
   always_comb begin
      state_d = state_q;
      // Saturate so idle/error dwell never wraps.
      cnt_d   = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;
      case (state_q)
         StOcioso: begin
            if (pulso_q[0] && !pulso_q[1]) state_d = StEnchendo;
         end
         StEnchendo: begin
            if (pulso_q[1])            state_d = StOcioso;
            else if (sync2_q[2])       state_d = StIrrigando;
            else if (cnt_q == EncheFim) state_d = StErro;
         end
         StIrrigando: begin
            if (pulso_q[1])             state_d = StOcioso;
            else if (cnt_q == IrrigaFim) state_d = StOcioso;
         end
         StErro: begin
            if (pulso_q[1]) state_d = StOcioso;
         end
         default: state_d = StOcioso;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   // State, dwell counter and registered Moore outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StOcioso;
         cnt_q     <= '0;
         valvula_q <= 1'b0;
         bomba_q   <= 1'b0;
         alarme_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         valvula_q <= (state_d == StEnchendo);
         bomba_q   <= (state_d == StIrrigando);
         alarme_q  <= (state_d == StErro);
      end
   end

   assign estado  = state_q;
   assign valvula = valvula_q;
   assign bomba   = bomba_q;
   assign alarme  = alarme_q;

endmodule

// File: tb/tb_controle_estado.sv
// Scoreboard bench for controle_estado: the driver pushes the expected outputs
// after every edge from a cycle-level behavioural model, a monitor compares.
module tb_controle_estado;

   localparam int D  = 4;
   localparam int TI = 10;
   localparam int TM = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       parar = 1'b0;
   logic       cheio = 1'b0;
   logic [1:0] estado;
   logic       valvula, bomba, alarme;

   int total = 0;
   int bad   = 0;
   int ciclo = 0;
   logic [4:0] exp_q [$];
   logic [4:0] want_mon;

   // Model: delayed raw samples, accepted levels, press streaks, state, dwell.
   bit m_d1 [3];
   bit m_d2 [3];
   bit m_acc [2];
   bit m_pulse [2];
   int m_streak [2];
   int m_st = 0;
   int m_elapsed = 0;

   controle_estado #(
      .DEBOUNCE_CICLOS(D),
      .TEMPO_IRRIGA(TI),
      .TEMPO_MAX_ENCHE(TM)
   ) dut (
      .clock(clock),
      .reset(reset),
      .iniciar(iniciar),
      .parar(parar),
      .cheio(cheio),
      .estado(estado),
      .valvula(valvula),
      .bomba(bomba),
      .alarme(alarme)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at cycle %0d: got estado/v/b/a=%b want %b", name, ciclo, got, want);
      end
   endtask

   // Expected outputs after the next edge, given the inputs seen by that edge.
   function void model_step(bit ini, bit par, bit ch, bit rst);
      int nst;
      if (rst) begin
         m_d1 = '{0, 0, 0};
         m_d2 = '{0, 0, 0};
         m_acc = '{0, 0};
         m_pulse = '{0, 0};
         m_streak = '{0, 0};
         m_st = 0;
         m_elapsed = 0;
      end else begin
         nst = m_st;
         case (m_st)
            0: if (m_pulse[0] && !m_pulse[1]) nst = 1;
            1: begin
               if (m_pulse[1]) nst = 0;
               else if (m_d2[2]) nst = 2;
               else if (m_elapsed + 1 == TM) nst = 3;
            end
            2: begin
               if (m_pulse[1]) nst = 0;
               else if (m_elapsed + 1 == TI) nst = 0;
            end
            default: if (m_pulse[1]) nst = 0;
         endcase
         m_elapsed = (nst != m_st) ? 0 : m_elapsed + 1;
         m_st = nst;
         for (int b = 0; b < 2; b++) begin
            m_pulse[b] = 0;
            if (m_d2[b] != m_acc[b]) begin
               m_streak[b]++;
               if (m_streak[b] == D) begin
                  m_acc[b] = m_d2[b];
                  m_pulse[b] = m_d2[b];
                  m_streak[b] = 0;
               end
            end else begin
               m_streak[b] = 0;
            end
         end
         m_d2 = m_d1;
         m_d1 = '{ini, par, ch};
      end
      exp_q.push_back({m_st[1:0], m_st == 1, m_st == 2, m_st == 3});
   endfunction

   task automatic cycle(input bit ini, input bit par, input bit ch, input bit rst);
      @(negedge clock);
      iniciar = ini;
      parar   = par;
      cheio   = ch;
      reset   = rst;
      model_step(ini, par, ch, rst);
   endtask

   task automatic hold(input bit ini, input bit par, input bit ch, input int n);
      repeat (n) cycle(ini, par, ch, 1'b0);
   endtask

   // Direct check of the DUT right after the edge whose inputs were last driven.
   task automatic expect_now(input string name, input logic [1:0] st);
      @(posedge clock);
      #2;
      check(name, {estado, valvula, bomba, alarme}, {st, st == 2'd1, st == 2'd2, st == 2'd3});
   endtask

   // Monitor: one expected entry per edge.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         ciclo++;
         if (exp_q.size() > 0) begin
            want_mon = exp_q.pop_front();
            check("ciclo", {estado, valvula, bomba, alarme}, want_mon);
         end
      end
   end

   initial begin
      bit ri, rp, rc;
      ri = 0;
      rp = 0;
      rc = 0;
      repeat (3) cycle(0, 0, 0, 1);
      expect_now("reset", 2'd0);

      // Short press ignored.
      hold(1, 0, 0, 3);
      hold(0, 0, 0, 10);
      expect_now("toque_curto", 2'd0);

      // Press latency, fill, irrigate for TI cycles.
      hold(1, 0, 0, 6);
      expect_now("latencia_antes", 2'd0);
      hold(1, 0, 0, 1);
      expect_now("latencia_enchendo", 2'd1);
      hold(1, 0, 0, 1);
      hold(0, 0, 0, 5);
      hold(0, 0, 1, 14);
      hold(0, 0, 0, 5);

      // Fill timeout to error, error ignores iniciar/cheio, parar clears.
      hold(1, 0, 0, 6);
      hold(0, 0, 0, 80);
      expect_now("erro", 2'd3);
      hold(1, 0, 1, 8);
      hold(0, 0, 0, 4);
      hold(0, 1, 0, 8);
      hold(0, 0, 0, 5);
      expect_now("erro_limpo", 2'd0);

      // Parar during irrigation, then a full run.
      hold(1, 0, 0, 8);
      hold(0, 0, 1, 2);
      hold(0, 1, 1, 8);
      hold(0, 0, 0, 5);
      hold(1, 0, 0, 8);
      hold(0, 0, 1, 16);
      hold(0, 0, 0, 4);

      // Simultaneous iniciar/parar in idle; parar with cheio while filling.
      hold(1, 1, 0, 8);
      hold(0, 0, 0, 4);
      expect_now("ini_par_juntos", 2'd0);
      hold(1, 0, 0, 8);
      hold(0, 1, 0, 4);
      hold(0, 1, 1, 4);
      expect_now("parar_vence_cheio", 2'd0);
      hold(0, 0, 0, 6);

      // Reset mid-irrigation, then a full run.
      hold(1, 0, 0, 8);
      hold(0, 0, 1, 7);
      cycle(0, 0, 1, 1);
      hold(0, 0, 0, 4);
      hold(1, 0, 0, 8);
      hold(0, 0, 1, 16);
      hold(0, 0, 0, 4);

      // Button held through reset counts as a new press.
      hold(1, 0, 0, 3);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 1);
      hold(1, 0, 0, 8);
      expect_now("botao_no_reset", 2'd1);
      hold(0, 1, 0, 8);
      hold(0, 0, 0, 4);

      // Random bouncing buttons, random tank sensor, occasional reset.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(5) == 0) ri = !ri;
         if (rp ? ($urandom_range(4) == 0) : ($urandom_range(39) == 0)) rp = !rp;
         if ($urandom_range(14) == 0) rc = !rc;
         cycle(ri, rp, rc, $urandom_range(299) == 0);
      end

      hold(0, 0, 0, 2);
      @(posedge clock);
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL fila: got %0d pending entries want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controle_estado.md
CONTROLE_ESTADO -- requirements
Module: controle_estado

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 4: consecutive stable cycles required to accept a button level (range 2..255).
REQ-002 Parameter TEMPO_IRRIGA, default 10: cycles spent in IRRIGANDO (range 1..65535).
REQ-003 Parameter TEMPO_MAX_ENCHE, default 20: maximum cycles in ENCHENDO before ERRO (range 1..65535).
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 iniciar  input  1  raw, asynchronous, bouncing start button (1 = pressed).
REQ-007 parar  input  1  raw, asynchronous, bouncing stop/acknowledge button (1 = pressed).
REQ-008 cheio  input  1  asynchronous tank-full sensor (1 = full), not debounced.
REQ-009 estado  output  2  current FSM state code, feeds the downstream 7-segment state-digit decoder.
REQ-010 valvula  output  1  fill valve command.
REQ-011 bomba  output  1  irrigation pump command.
REQ-012 alarme  output  1  fault indicator.

Function
REQ-013 Each of iniciar, parar, cheio SHALL pass through a 2-flop synchronizer before any use.
REQ-014 iniciar and parar SHALL each have a debouncer: an accepted level register plus a counter, cleared whenever the synchronized level equals the accepted level.
REQ-015 Debouncer: the counter increments each cycle the synchronized level differs from the accepted level; on the cycle it would reach DEBOUNCE_CICLOS, the accepted level SHALL update and the counter SHALL clear.
REQ-016 Each debouncer SHALL emit a one-cycle internal pulse on an accepted 0->1 transition only; no pulse on release.
REQ-017 A raw button rising before edge k and held steady SHALL change estado at edge k+2+DEBOUNCE_CICLOS; a press shorter than DEBOUNCE_CICLOS synchronized cycles SHALL have no effect.
REQ-018 A raw cheio rising before edge k and held SHALL be acted on at edge k+2.
REQ-019 States and codes: OCIOSO = 2'b00, ENCHENDO = 2'b01, IRRIGANDO = 2'b10, ERRO = 2'b11; estado SHALL equal the state register directly.
REQ-020 OCIOSO: iniciar pulse without parar pulse -> ENCHENDO; otherwise stay.
REQ-021 ENCHENDO: parar pulse -> OCIOSO; else synchronized cheio = 1 -> IRRIGANDO; else after exactly TEMPO_MAX_ENCHE cycles in ENCHENDO -> ERRO.
REQ-022 IRRIGANDO: parar pulse -> OCIOSO; else after exactly TEMPO_IRRIGA cycles in IRRIGANDO -> OCIOSO.
REQ-023 ERRO: parar pulse -> OCIOSO; iniciar and cheio SHALL be ignored.
REQ-024 Priority within any cycle SHALL be parar > cheio > timeout > iniciar.
REQ-025 A single 16-bit cycle counter SHALL clear on every state transition and never wrap inside a state.
REQ-026 Outputs are Moore decodes of the state: valvula = 1 only in ENCHENDO, bomba = 1 only in IRRIGANDO, alarme = 1 only in ERRO, all glitch-free.
REQ-027 If cheio is already 1 on entry to ENCHENDO, the block SHALL go to IRRIGANDO on the following edge, with ENCHENDO lasting 1 cycle.

Reset
REQ-028 With reset = 1 at an edge: estado = 00; valvula, bomba, alarme = 0; synchronizers, accepted levels, debounce counters and cycle counter = 0.
REQ-029 Reset SHALL override all inputs, including mid-operation in any state.
REQ-030 A button held through reset release SHALL register as a new press after debounce.

Verification (DEBOUNCE_CICLOS=4, TEMPO_IRRIGA=10, TEMPO_MAX_ENCHE=20)
REQ-031 iniciar high for 3 cycles, then low -> estado stays 00 and no output asserts.
REQ-032 iniciar high from edge k for 8 cycles -> estado 01 and valvula=1 at edge k+6; cheio high before edge m -> estado 10 and bomba=1 at m+2 for exactly 10 cycles, then 00.
REQ-033 iniciar press, cheio held 0 -> estado 01 for exactly 20 cycles, then 11 with alarme=1; stays 11 for 50 cycles; debounced parar -> 00 and alarme=0.
REQ-034 Debounced parar press during IRRIGANDO at cycle 5 -> estado 00 and bomba=0 at the press edge; counter restarts from 0 on the next run.
REQ-035 iniciar and parar rise in the same cycle while in OCIOSO -> estado stays 00; in ENCHENDO, parar with cheio=1 in the same cycle -> 00.
REQ-036 reset pulse during IRRIGANDO at cycle 4 -> estado 00 and all outputs 0 at that edge; a new full cycle then runs 10 IRRIGANDO cycles.
